// File: rtl/lenet_cfg_pkg.sv
// Shared configuration for the LeNet RAM read-side sequencer: layer encodings,
// feature-map sizes, controller states and the read-pipe tag bundle.
package lenet_cfg_pkg;

    typedef enum logic [2:0] {
        MODE_C1 = 3'd0,
        MODE_C2 = 3'd1,
        MODE_C3 = 3'd2,
        MODE_C4 = 3'd3,
        MODE_C5 = 3'd4
    } lenet_mode_e;

    // RAM read latency plus the ram_buffer output register
    localparam int RD_LATENCY = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_PRE,
        ST_W_LOAD,
        ST_I_PRE,
        ST_I_STREAM,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_e;

    typedef struct packed {
        logic       is_weight;
        logic [4:0] row;
        logic [4:0] col;
    } rd_tag_t;

    function automatic logic [5:0] fmap_side(input logic [2:0] mode);
        case (mode)
            MODE_C1: return 6'd32;
            MODE_C2: return 6'd28;
            MODE_C3: return 6'd14;
            MODE_C4: return 6'd10;
            MODE_C5: return 6'd5;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/valid_delay_pipe.sv
// Fixed-depth delay line for the read-issue strobe and its tag, so the valid
// flags line up with the data leaving ram_buffer.
module valid_delay_pipe
    import lenet_cfg_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    in_valid,
    input  rd_tag_t in_tag,
    output logic    out_valid,
    output rd_tag_t out_tag
);

    logic [DEPTH-1:0] valid_q;
    rd_tag_t          tag_q [DEPTH];

    // Flush drops the incoming strobe too, so nothing issued in the abort cycle survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/ram_buffer_ctrl.sv
// Read-side sequencer for ram_buffer: optional linear weight burst followed by
// one raster-order feature-map stream, with valids aligned to the RAM output.
module ram_buffer_ctrl
    import lenet_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH        = 11,
    parameter int FEATURE_MAP1_SIZE = 32,
    parameter int FEATURE_MAP2_SIZE = 28,
    parameter int FEATURE_MAP3_SIZE = 14,
    parameter int FEATURE_MAP4_SIZE = 10,
    parameter int FEATURE_MAP5_SIZE = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            cfg_mode,
    input  logic [ADDR_WIDTH-1:0] cfg_w_base,
    input  logic [ADDR_WIDTH-1:0] cfg_w_count,
    input  logic [ADDR_WIDTH-1:0] cfg_img_base,
    output logic                  WorI,
    output logic                  en,
    output logic [2:0]            mode,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  weight_valid,
    output logic                  pix_valid,
    output logic [4:0]            pix_row,
    output logic [4:0]            pix_col,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    ctrl_state_e           state_q, state_d;
    logic [2:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] img_base_q;
    logic [ADDR_WIDTH-1:0] w_count_q;
    logic [ADDR_WIDTH-1:0] w_idx_q;
    logic [4:0]            row_q, col_q;
    logic [4:0]            side_m1;
    logic                  drain_q;
    logic                  cfg_err_q;
    logic                  start_ok;
    logic                  w_last;
    logic                  pix_last;
    rd_tag_t               issue_tag;
    logic                  pipe_valid;
    rd_tag_t               pipe_tag;

    always_comb begin
        side_m1 = 5'(FEATURE_MAP1_SIZE - 1);
        case (mode_q)
            MODE_C2: side_m1 = 5'(FEATURE_MAP2_SIZE - 1);
            MODE_C3: side_m1 = 5'(FEATURE_MAP3_SIZE - 1);
            MODE_C4: side_m1 = 5'(FEATURE_MAP4_SIZE - 1);
            MODE_C5: side_m1 = 5'(FEATURE_MAP5_SIZE - 1);
            default: side_m1 = 5'(FEATURE_MAP1_SIZE - 1);
        endcase
    end

    assign start_ok = start && !abort && (cfg_mode <= MODE_C5);
    assign w_last   = (w_idx_q == w_count_q - ADDR_WIDTH'(1));
    assign pix_last = (row_q == side_m1) && (col_q == side_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start_ok) state_d = (cfg_w_count != '0) ? ST_W_PRE : ST_I_PRE;
            ST_W_PRE:    state_d = ST_W_LOAD;
            ST_W_LOAD:   if (w_last) state_d = ST_I_PRE;
            ST_I_PRE:    state_d = ST_I_STREAM;
            ST_I_STREAM: if (pix_last) state_d = ST_DRAIN;
            ST_DRAIN:    if (drain_q) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Raster order over a contiguous block means the pixel address is just a running increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            addr_q     <= '0;
            img_base_q <= '0;
            w_count_q  <= '0;
            w_idx_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            drain_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            if (abort) begin
                w_idx_q <= '0;
                row_q   <= '0;
                col_q   <= '0;
                drain_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        cfg_err_q <= start && (cfg_mode > MODE_C5);
                        if (start_ok) begin
                            mode_q     <= cfg_mode;
                            img_base_q <= cfg_img_base;
                            w_count_q  <= cfg_w_count;
                            addr_q     <= (cfg_w_count != '0) ? cfg_w_base : cfg_img_base;
                            w_idx_q    <= '0;
                            row_q      <= '0;
                            col_q      <= '0;
                            drain_q    <= 1'b0;
                        end
                    end
                    ST_W_LOAD: begin
                        w_idx_q <= w_idx_q + ADDR_WIDTH'(1);
                        addr_q  <= w_last ? img_base_q : addr_q + ADDR_WIDTH'(1);
                    end
                    ST_I_STREAM: begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (col_q == side_m1) begin
                            col_q <= '0;
                            row_q <= row_q + 5'd1;
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                    ST_DRAIN: drain_q <= 1'b1;
                    default:  drain_q <= 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        issue_tag           = '0;
        issue_tag.is_weight = (state_q == ST_W_LOAD);
        if (state_q == ST_I_STREAM) begin
            issue_tag.row = row_q;
            issue_tag.col = col_q;
        end
    end

    valid_delay_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .in_valid (en),
        .in_tag   (issue_tag),
        .out_valid(pipe_valid),
        .out_tag  (pipe_tag)
    );

    assign en           = (state_q == ST_W_LOAD) || (state_q == ST_I_STREAM);
    assign WorI         = (state_q == ST_W_PRE) || (state_q == ST_W_LOAD);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign cfg_err      = cfg_err_q;
    assign mode         = mode_q;
    assign read_addr    = addr_q;
    assign weight_valid = pipe_valid && pipe_tag.is_weight;
    assign pix_valid    = pipe_valid && !pipe_tag.is_weight;
    assign pix_row      = pix_valid ? pipe_tag.row : 5'd0;
    assign pix_col      = pix_valid ? pipe_tag.col : 5'd0;

endmodule
